sram_block_reader: RTL and testbench

SRAM_BLOCK_READER -- requirements
Module: sram_block_reader

---
 rtl/rsa_pkg.sv | 36 +++
 rtl/rsa_fifo2.sv | 57 +++++
 rtl/sram_block_reader.sv | 121 ++++++++++++
 tb/tb_sram_block_reader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_pkg : shared constants, region bases and FSM encoding for the block reader
// Revision: 1.0
// ----------------------------------------------------------------------------
package rsa_pkg;

    localparam int c_WORDS  = 64;
    localparam int c_DATA_W = 32;
    localparam int c_ADDR_W = 8;
    localparam int c_IDX_W  = 6;

    localparam logic [7:0] c_BASE_DATA = 8'd0;
    localparam logic [7:0] c_BASE_KEY  = 8'd64;
    localparam logic [7:0] c_BASE_N    = 8'd128;
    localparam logic [7:0] c_BASE_R3   = 8'd192;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [7:0] region_base(input logic [1:0] region);
        logic [7:0] base;
        case (region)
            2'd0:    base = c_BASE_DATA;
            2'd1:    base = c_BASE_KEY;
            2'd2:    base = c_BASE_N;
            default: base = c_BASE_R3;
        endcase
        return base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_fifo2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rsa_fifo2 : two-entry FIFO; the head entry stays put until it is popped
// Revision: 1.0
// ----------------------------------------------------------------------------
module rsa_fifo2 #(
    parameter int WIDTH = 39
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && (count_q != 2'd2);
    assign pop_ok  = pop_i && (count_q != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/sram_block_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_block_reader : streams one WORDS-word SRAM block as a ready/valid stream
// Revision: 1.0
// ----------------------------------------------------------------------------
module sram_block_reader
    import rsa_pkg::*;
#(
    parameter int WORDS  = c_WORDS,
    parameter int DATA_W = c_DATA_W,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         region_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               sram_en_o,
    output logic [ADDR_W-1:0]  sram_addr_o,
    input  logic [DATA_W-1:0]  sram_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_data_o,
    output logic [c_IDX_W-1:0] out_index_o,
    output logic               out_last_o
);

    localparam int               c_FIFO_W   = DATA_W + c_IDX_W + 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    state_e             state_q;
    logic [ADDR_W-1:0]  base_q;
    logic [c_IDX_W-1:0] issue_q;
    logic               inflight_q;
    logic [c_IDX_W-1:0] inflight_idx_q;
    logic               done_q;

    logic [1:0]          fifo_count;
    logic                fifo_valid;
    logic [c_FIFO_W-1:0] fifo_head;
    logic [c_FIFO_W-1:0] fifo_wdata;
    logic                pop;
    logic                issue;
    logic [1:0]          occ_d;

    assign pop = fifo_valid && out_ready_i;

    // Occupancy is taken after this cycle's pop so a streaming consumer keeps
    // a read issued every cycle; total slots claimed never exceed two.
    assign occ_d = fifo_count - {1'b0, pop} + {1'b0, inflight_q};
    assign issue = (state_q == ST_FETCH) && (occ_d < 2'd2);

    assign sram_en_o   = issue;
    assign sram_addr_o = issue ? (base_q + ADDR_W'(issue_q)) : '0;

    assign fifo_wdata = {sram_data_i, inflight_idx_q, (inflight_idx_q == c_LAST_IDX)};

    rsa_fifo2 #(
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            issue_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            if (issue) begin
                inflight_idx_q <= issue_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_FETCH;
                        base_q  <= ADDR_W'(region_base(region_i));
                        issue_q <= '0;
                    end
                end
                ST_FETCH: begin
                    if (issue) begin
                        issue_q <= issue_q + c_IDX_W'(1);
                        if (issue_q == c_LAST_IDX) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && fifo_head[0]) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done_q;
    assign out_valid_o = fifo_valid;
    assign out_data_o  = fifo_head[c_FIFO_W-1 -: DATA_W];
    assign out_index_o = fifo_head[c_IDX_W:1];
    assign out_last_o  = fifo_head[0];

endmodule
`default_nettype wire

// File: tb/tb_sram_block_reader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sram_block_reader : directed block-fetch vectors plus reset/stall/restart cases
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_sram_block_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  region_i;
    logic        busy_o;
    logic        done_o;
    logic        sram_en_o;
    logic [7:0]  sram_addr_o;
    logic [31:0] sram_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_data_o;
    logic [5:0]  out_index_o;
    logic        out_last_o;

    sram_block_reader dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .region_i    (region_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sram_en_o   (sram_en_o),
        .sram_addr_o (sram_addr_o),
        .sram_data_i (sram_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_index_o (out_index_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [7:0] a);
        return {8'hC3, a, ~a, a ^ 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (sram_en_o) sram_data_i <= ram_word(sram_addr_o);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state tracked by the monitor
    bit          mon_en = 1'b0;
    int          exp_base = 0;
    int          exp_issue = 0;
    int          exp_idx = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    int          first_pop = 0;
    int          last_pop = 0;
    bit          pend_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [31:0] sv_data;
    logic [5:0]  sv_idx;
    logic        sv_last;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (sram_en_o) begin
                check("sram_addr", 32'(sram_addr_o), 32'(exp_base + exp_issue));
                exp_issue++;
            end
            check("done", 32'(done_o), 32'(pend_done));
            if (done_o) done_cnt++;
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_data", out_data_o, sv_data);
                check("hold_index", 32'(out_index_o), 32'(sv_idx));
                check("hold_last", 32'(out_last_o), 32'(sv_last));
            end
            pend_done = 1'b0;
            if (out_valid_o && out_ready_i) begin
                check("out_data", out_data_o, ram_word(8'(exp_base + exp_idx)));
                check("out_index", 32'(out_index_o), 32'(exp_idx));
                check("out_last", 32'(out_last_o), 32'(exp_idx == 63));
                if (exp_idx == 0) first_pop = cyc;
                last_pop = cyc;
                if (exp_idx == 63) pend_done = 1'b1;
                exp_idx++;
            end
            prev_stall = out_valid_o && !out_ready_i;
            sv_data = out_data_o;
            sv_idx  = out_index_o;
            sv_last = out_last_o;
        end
    end

    // mode 0: always ready, 1: toggle, 2: random, 3: stalled until cycle 'stall'
    function automatic logic ready_val(input int mode, input int n, input int stall);
        case (mode)
            0:       return 1'b1;
            1:       return n[0];
            2:       return 1'($urandom);
            default: return (n >= stall);
        endcase
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy_o), 32'd0);
        check({tag, "_done"}, 32'(done_o), 32'd0);
        check({tag, "_sram_en"}, 32'(sram_en_o), 32'd0);
        check({tag, "_sram_addr"}, 32'(sram_addr_o), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_out_data"}, out_data_o, 32'd0);
        check({tag, "_out_index"}, 32'(out_index_o), 32'd0);
        check({tag, "_out_last"}, 32'(out_last_o), 32'd0);
    endtask

    task automatic run_block(input logic [1:0] region, input int mode, input int base,
                             input int restart_at, input int stall, input int rst_at);
        int n;
        bit restarted;
        restarted = 1'b0;
        @(posedge clk); #1;
        exp_base   = base;
        exp_issue  = 0;
        exp_idx    = 0;
        done_cnt   = 0;
        pend_done  = 1'b0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        region_i   = region;
        start_i    = 1'b1;
        out_ready_i = ready_val(mode, 0, stall);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_start", 32'(busy_o), 32'd1);
        check("valid_c0", 32'(out_valid_o), 32'd0);
        n = 0;
        while ((exp_idx < 64 || done_cnt == 0) && n < 600) begin
            out_ready_i = ready_val(mode, n, stall);
            region_i = 2'($urandom);
            start_i = 1'b0;
            if (restart_at >= 0 && !restarted && exp_idx == restart_at) begin
                start_i   = 1'b1;
                region_i  = 2'd3;
                restarted = 1'b1;
            end
            if (rst_at >= 0 && exp_idx == rst_at) begin
                mon_en = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                // Release before the outstanding read returns so it must be dropped
                #1;
                rst = 1'b0;
                out_ready_i = 1'b0;
                return;
            end
            if (n == 1) check("valid_c1", 32'(out_valid_o), 32'd0);
            if (n == 2) check("first_valid_c2", 32'(out_valid_o), 32'd1);
            if (stall > 0 && n == stall) begin
                check("stall_reads_le2", 32'(exp_issue <= 2), 32'd1);
                check("stall_valid", 32'(out_valid_o), 32'd1);
                check("stall_data", out_data_o, ram_word(8'(base)));
            end
            @(posedge clk); #1;
            n++;
        end
        start_i = 1'b0;
        check("block_timeout", 32'(n < 600), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt), 32'd1);
        check("idle_after", 32'(busy_o), 32'd0);
        check("reads_total", 32'(exp_issue), 32'd64);
        check("words_total", 32'(exp_idx), 32'd64);
        if (mode == 0) check("throughput", 32'(last_pop - first_pop), 32'd63);
        mon_en = 1'b0;
        out_ready_i = 1'b0;
    endtask

    typedef struct {
        logic [1:0] region;
        int         mode;
        int         base;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{region: 2'd1, mode: 0, base: 64};
        vecs[1] = '{region: 2'd2, mode: 1, base: 128};
        vecs[2] = '{region: 2'd3, mode: 0, base: 192};
        vecs[3] = '{region: 2'd0, mode: 2, base: 0};

        rst = 1'b1;
        start_i = 1'b0;
        region_i = 2'd0;
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_block(vecs[i].region, vecs[i].mode, vecs[i].base, -1, 0, -1);
        end

        run_block(2'd0, 3, 0, -1, 20, -1);
        run_block(2'd0, 1, 0, 10, 0, -1);
        run_block(2'd1, 0, 64, -1, 0, 30);
        run_block(2'd2, 0, 128, -1, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
